// File: rtl/cpu_pkg.sv
// Shared core types: mul/div sequencer states and default mul/div latencies.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } md_state_t;

    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;

    // Width of a down-counter holding up to max(a,b)-1, never less than 1 bit.
    function automatic int md_cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// Hazard inputs from the pipeline and stall/flush/mul-div status back to it.
interface stall_ctrl_if;
    logic        MemReadE;
    logic        RegWriteE;
    logic [4:0]  RAddrE;
    logic        MemReadM;
    logic [4:0]  RAddrM;
    logic [4:0]  RsAddrD;
    logic [4:0]  RtAddrD;
    logic        BranchD;
    logic        MdUseD;
    logic        MdStartE;
    logic        MdDivE;
    logic        MemStallM;
    logic        StallF;
    logic        StallD;
    logic        StallE;
    logic        StallM;
    logic        FlushE;
    logic        MdBusy;
    logic        MdDone;
    logic [31:0] StallCnt;

    // Pipeline side
    modport master (
        output MemReadE, RegWriteE, RAddrE, MemReadM, RAddrM, RsAddrD, RtAddrD,
               BranchD, MdUseD, MdStartE, MdDivE, MemStallM,
        input  StallF, StallD, StallE, StallM, FlushE, MdBusy, MdDone, StallCnt
    );

    // Controller side
    modport slave (
        input  MemReadE, RegWriteE, RAddrE, MemReadM, RAddrM, RsAddrD, RtAddrD,
               BranchD, MdUseD, MdStartE, MdDivE, MemStallM,
        output StallF, StallD, StallE, StallM, FlushE, MdBusy, MdDone, StallCnt
    );
endinterface

// File: rtl/stall_ctrl_md_sequencer.sv
// Mul/div occupancy sequencer: IDLE -> BUSY (N cycles) -> DONE (1 cycle) -> IDLE.
// Latency: busy from the cycle after start, done in cycle N+1; start outside IDLE is ignored.
module md_sequencer
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic nrst,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);
    localparam int CW = md_cnt_width(MUL_CYCLES, DIV_CYCLES);

    md_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: rtl/stall_ctrl.sv
// Hazard/stall controller: load-use, branch-in-D, mem wait and mul/div busy -> stage stalls and EX flush.
// Latency: stall/flush combinational (0 cycles); optional StallCnt (STALL_CTRL_PERF_EN) counts StallD cycles.
// Backpressure: a data-memory wait freezes all four stage registers and overrides every other hazard.
module stall_ctrl
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         nrst,
    stall_ctrl_if.slave  bus
);
    logic e_hits_d;
    logic m_hits_d;
    logic haz_lu;
    logic haz_br;
    logic haz_md;
    logic md_busy;
    logic md_done;
    logic stall_d;

    assign e_hits_d = (bus.RAddrE != 5'd0) &&
                      ((bus.RAddrE == bus.RsAddrD) || (bus.RAddrE == bus.RtAddrD));
    assign m_hits_d = (bus.RAddrM != 5'd0) &&
                      ((bus.RAddrM == bus.RsAddrD) || (bus.RAddrM == bus.RtAddrD));

    assign haz_lu = bus.MemReadE && e_hits_d;
    // Branches resolve in D, so they also wait on ALU results still in EX and loads still in MEM.
    assign haz_br = bus.BranchD && ((bus.RegWriteE && e_hits_d) || (bus.MemReadM && m_hits_d));
    assign haz_md = bus.MdUseD && md_busy;

    md_sequencer #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_seq (
        .clk    (clk),
        .nrst   (nrst),
        .start  (bus.MdStartE && !bus.MemStallM),
        .is_div (bus.MdDivE),
        .busy   (md_busy),
        .done   (md_done)
    );

    always_comb begin
        bus.StallF = 1'b0;
        bus.StallD = 1'b0;
        bus.StallE = 1'b0;
        bus.StallM = 1'b0;
        bus.FlushE = 1'b0;
        if (bus.MemStallM) begin
            bus.StallF = 1'b1;
            bus.StallD = 1'b1;
            bus.StallE = 1'b1;
            bus.StallM = 1'b1;
        end else if (haz_lu || haz_br || haz_md) begin
            bus.StallF = 1'b1;
            bus.StallD = 1'b1;
            bus.FlushE = 1'b1;
        end
    end

    assign stall_d    = bus.StallD;
    assign bus.MdBusy = md_busy;
    assign bus.MdDone = md_done;

`ifdef STALL_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            stall_cnt_q <= '0;
        else if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign bus.StallCnt = stall_cnt_q;
`else
    assign bus.StallCnt = 32'd0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Bench for stall_ctrl: table of combinational hazard vectors plus mul/div, memory-stall and reset sequences.
module tb_stall_ctrl;
    logic clk;
    logic nrst;

    stall_ctrl_if sif();

    stall_ctrl #(.MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       mem_read_e;
        logic       reg_write_e;
        logic [4:0] raddr_e;
        logic       mem_read_m;
        logic [4:0] raddr_m;
        logic [4:0] rs_d;
        logic [4:0] rt_d;
        logic       branch_d;
        logic       md_use_d;
        logic       md_start_e;
        logic       md_div_e;
        logic       mem_stall_m;
    } in_t;

    // {StallF, StallD, StallE, StallM, FlushE, MdBusy, MdDone}
    typedef struct packed {
        logic sf, sd, se, sm, fe, busy, done;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam out_t O_NONE = 7'b0000000;
    localparam out_t O_HZ   = 7'b1100100;
    localparam out_t O_MEM  = 7'b1111000;

    int    errors = 0;
    int    checks = 0;
    out_t  exp_q[$];
    logic [31:0] exp_cnt = 32'd0;

    task automatic drive(input in_t i);
        sif.MemReadE  = i.mem_read_e;
        sif.RegWriteE = i.reg_write_e;
        sif.RAddrE    = i.raddr_e;
        sif.MemReadM  = i.mem_read_m;
        sif.RAddrM    = i.raddr_m;
        sif.RsAddrD   = i.rs_d;
        sif.RtAddrD   = i.rt_d;
        sif.BranchD   = i.branch_d;
        sif.MdUseD    = i.md_use_d;
        sif.MdStartE  = i.md_start_e;
        sif.MdDivE    = i.md_div_e;
        sif.MemStallM = i.mem_stall_m;
    endtask

    function automatic out_t sample();
        return {sif.StallF, sif.StallD, sif.StallE, sif.StallM, sif.FlushE, sif.MdBusy, sif.MdDone};
    endfunction

    task automatic check_cnt(input string nm, input logic [31:0] want);
        checks++;
        if (sif.StallCnt !== want) begin
            errors++;
            $display("FAIL %s: StallCnt got %0d want %0d", nm, sif.StallCnt, want);
        end
    endtask

    // One pipeline cycle: drive after the edge, queue expectation, compare on the falling edge.
    task automatic apply(input in_t i, input out_t o, input string nm);
        out_t got;
        out_t want;
        @(posedge clk);
        #1;
        drive(i);
        exp_q.push_back(o);
        @(negedge clk);
        want = exp_q.pop_front();
        got  = sample();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: outputs got %b want %b (sf sd se sm fe busy done)", nm, got, want);
        end
        check_cnt({nm, "_cnt"}, exp_cnt);
`ifdef STALL_CTRL_PERF_EN
        if (want.sd && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
`endif
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear without waiting for an edge.
    task automatic mid_reset(input string nm);
        @(posedge clk);
        #2;
        nrst = 1'b0;
        exp_cnt = 32'd0;
        #1;
        checks++;
        if (sample() !== O_NONE) begin
            errors++;
            $display("FAIL %s: outputs got %b want %b", nm, sample(), O_NONE);
        end
        check_cnt({nm, "_cnt"}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic run_mul(input string tag);
        in_t  t;
        out_t o;
        for (int c = 0; c <= 6; c++) begin
            t = '0;
            if (c == 0) t.md_start_e = 1'b1;
            if (c >= 1) t.md_use_d = 1'b1;
            if (c == 2) begin
                t.mem_read_e = 1'b1;
                t.raddr_e    = 5'd5;
                t.rs_d       = 5'd5;
            end
            o = O_NONE;
            if (c >= 1 && c <= 5) o = O_HZ;
            o.busy = (c >= 1 && c <= 5);
            o.done = (c == 5);
            apply(t, o, $sformatf("%s_c%0d", tag, c));
        end
    endtask

    always @(negedge clk) begin
        if (nrst && sif.MdStartE && sif.MdBusy) begin
            checks++;
            errors++;
            $display("FAIL protocol: MdStartE=1 while MdBusy=1");
        end
    end

    initial begin
        vec_t tbl[$];
        in_t  t;
        out_t o;

        drive('0);
        nrst = 1'b0;
        #3;
        checks++;
        if (sample() !== O_NONE) begin
            errors++;
            $display("FAIL reset: outputs got %b want %b", sample(), O_NONE);
        end
        check_cnt("reset_cnt", 32'd0);
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;

        t = '0;                                                        tbl.push_back('{t, O_NONE});
        t = '0; t.mem_read_e = 1; t.raddr_e = 5; t.rs_d = 5;           tbl.push_back('{t, O_HZ});
        t = '0; t.mem_read_e = 1; t.raddr_e = 5; t.rt_d = 5;           tbl.push_back('{t, O_HZ});
        t = '0; t.mem_read_e = 1; t.raddr_e = 0; t.rs_d = 0;           tbl.push_back('{t, O_NONE});
        t = '0; t.mem_read_e = 1; t.raddr_e = 5; t.rs_d = 6; t.rt_d = 7; tbl.push_back('{t, O_NONE});
        t = '0; t.reg_write_e = 1; t.raddr_e = 7; t.rt_d = 7;          tbl.push_back('{t, O_NONE});
        t = '0; t.branch_d = 1; t.reg_write_e = 1; t.raddr_e = 7; t.rt_d = 7; tbl.push_back('{t, O_HZ});
        t = '0; t.branch_d = 1; t.mem_read_m = 1; t.raddr_m = 7; t.rt_d = 7;  tbl.push_back('{t, O_HZ});
        t = '0; t.branch_d = 1; t.rt_d = 7;                            tbl.push_back('{t, O_NONE});
        t = '0; t.branch_d = 1; t.reg_write_e = 1; t.raddr_e = 0; t.rs_d = 0; tbl.push_back('{t, O_NONE});
        t = '0; t.branch_d = 1; t.mem_read_m = 1; t.raddr_m = 0; t.rs_d = 0;  tbl.push_back('{t, O_NONE});
        t = '0; t.mem_read_m = 1; t.raddr_m = 7; t.rs_d = 7;           tbl.push_back('{t, O_NONE});
        t = '0; t.mem_stall_m = 1;                                     tbl.push_back('{t, O_MEM});
        t = '0; t.mem_stall_m = 1; t.mem_read_e = 1; t.raddr_e = 3; t.rs_d = 3; tbl.push_back('{t, O_MEM});
        t = '0; t.md_use_d = 1;                                        tbl.push_back('{t, O_NONE});
        t = '0; t.md_start_e = 1; t.mem_stall_m = 1;                   tbl.push_back('{t, O_MEM});
        t = '0;                                                        tbl.push_back('{t, O_NONE});

        foreach (tbl[k]) apply(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));

        run_mul("mul");

        for (int c = 0; c <= 34; c++) begin
            t = '0;
            if (c == 0) begin
                t.md_start_e = 1'b1;
                t.md_div_e   = 1'b1;
            end
            if (c >= 1) t.md_use_d = 1'b1;
            if (c >= 3 && c <= 10) t.mem_stall_m = 1'b1;
            o = O_NONE;
            if (c >= 3 && c <= 10)      o = O_MEM;
            else if (c >= 1 && c <= 33) o = O_HZ;
            o.busy = (c >= 1 && c <= 33);
            o.done = (c == 33);
            apply(t, o, $sformatf("div_c%0d", c));
        end

        t = '0; t.md_start_e = 1; t.md_div_e = 1;
        o = O_NONE;
        apply(t, o, "divabort_c0");
        t = '0; o.busy = 1'b1;
        apply(t, o, "divabort_c1");
        mid_reset("divabort_rst");
        for (int c = 0; c < 36; c++) apply('0, O_NONE, $sformatf("divabort_idle%0d", c));
        run_mul("mul_after_rst");

        mid_reset("perf_rst");
        t = '0; t.mem_read_e = 1; t.raddr_e = 9; t.rt_d = 9;
        for (int c = 0; c < 10; c++) apply(t, O_HZ, $sformatf("perf_c%0d", c));
        apply('0, O_NONE, "perf_end");
`ifdef STALL_CTRL_PERF_EN
        check_cnt("perf_total", 32'd10);
`else
        check_cnt("perf_total", 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Pipeline hazard and stall controller for the 5-stage core. It works alongside the forwarding unit and covers the hazards that forwarding cannot resolve: load-use, a branch in decode reading an unfinished result, a data-memory wait, and the busy window of the multi-cycle multiply/divide unit. It sequences that unit with an internal FSM and counter. It drives every stage-register stall and flush control.

## Interface
Parameters:
- MUL_CYCLES, 4, execution cycles of a multiply (≥1)
- DIV_CYCLES, 32, execution cycles of a divide (≥1)

Ports:
- clk  in  1  core clock, rising edge
- nrst  in  1  asynchronous, active-low reset
- MemReadE  in  1  EX instruction is a load
- RegWriteE  in  1  EX instruction writes the register file
- RAddrE  in  5  EX destination register
- MemReadM  in  1  MEM instruction is a load
- RAddrM  in  5  MEM destination register
- RsAddrD, RtAddrD  in  5  each  D source registers
- BranchD  in  1  D instruction is a branch resolved in D
- MdUseD  in  1  D instruction reads HI/LO or is a mul/div
- MdStartE  in  1  EX instruction launches a mul/div
- MdDivE  in  1  1 = divide, 0 = multiply (qualified by MdStartE)
- MemStallM  in  1  data memory not ready
- StallF, StallD, StallE, StallM  out  1  each  hold the stage register
- FlushE  out  1  insert a bubble into the D→E register
- MdBusy  out  1  mul/div unit occupied
- MdDone  out  1  one-cycle pulse: HI/LO written at the end of this cycle
- StallCnt  out  32  stall-cycle counter (see Configuration)

## Operation
- Hazard terms (combinational):
  - LU = MemReadE & RAddrE≠0 & (RAddrE==RsAddrD | RAddrE==RtAddrD)
  - BR = BranchD & [(RegWriteE & RAddrE≠0 & RAddrE matches RsAddrD/RtAddrD) | (MemReadM & RAddrM≠0 & RAddrM matches RsAddrD/RtAddrD)]
  - MD = MdUseD & MdBusy
- Priority:
  1. MemStallM=1: StallF=StallD=StallE=StallM=1, FlushE=0. This overrides everything else.
  2. LU | BR | MD: StallF=StallD=FlushE=1, StallE=StallM=0.
  3. Otherwise all outputs 0.
- Mul/div FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY when MdStartE & !MemStallM. The counter loads (MdDivE ? DIV_CYCLES : MUL_CYCLES)−1.
  - In BUSY the counter decrements each cycle. BUSY→DONE when the counter reaches 0.
  - DONE→IDLE unconditionally after one cycle.
  - MdBusy=1 in BUSY and DONE. MdDone=1 only in DONE.
- MdStartE outside IDLE is a protocol violation. The block ignores it; the bench asserts it never occurs.
- The counter and FSM advance regardless of MemStallM.
- The counter is $clog2(max(MUL_CYCLES,DIV_CYCLES)) bits wide, with a minimum of 1. It never underflows: it is loaded only in IDLE.

## Timing
- Stall and flush outputs are combinational, with zero-cycle latency from their inputs.
- Reset (nrst=0, asynchronous): FSM goes to IDLE, counter=0, StallCnt=0, MdBusy=0, MdDone=0. With quiescent inputs all stall and flush outputs are 0.
- Reset mid-operation aborts the mul/div immediately. No MdDone is produced.
- Start accepted at the edge ending cycle T: BUSY occupies cycles T+1..T+N, DONE is cycle T+N+1. A dependent MdUseD instruction leaves D at the earliest in cycle T+N+2.
- Simultaneous LU and MD produce a single stall; the D instruction stays held until every term clears.

## Configuration
- Macro: STALL_CTRL_PERF_EN.
- Defined: StallCnt increments by 1 on every cycle with StallD=1. It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Undefined: no counter logic is built and StallCnt is tied to 0. The port list is identical in both builds.

## Structure
- Shared package `cpu_pkg` holds:
  - the `md_state_t` enum (IDLE, BUSY, DONE)
  - the default cycle constants MUL_CYCLES_DEF and DIV_CYCLES_DEF
- Sub-module `md_sequencer` contains the FSM and down-counter.
  - Inputs: clk, nrst, start, is_div.
  - Outputs: busy, done.
- `stall_ctrl` holds the hazard decode, the priority logic and the optional perf counter.

## Test plan
- Load-use: MemReadE=1, RAddrE=5, RsAddrD=5 → StallF=StallD=FlushE=1 for that cycle. With RAddrE=0 → all outputs 0.
- Branch after ALU and after load:
  - BranchD=1, RegWriteE=1, RAddrE=7, RtAddrD=7 → stall.
  - Next cycle, MemReadM=1, RAddrM=7 → stall.
  - Then release.
- Multiply, MUL_CYCLES=4: start at cycle 0 → MdBusy=1 in cycles 1–5, MdDone=1 in cycle 5 only. MdUseD held from cycle 1 → stall cycles 1–5, released in cycle 6.
- Divide with MemStallM=1 during cycles 3–10, DIV_CYCLES=32 → MdDone still in cycle 33. During the memory stall: all four Stall outputs=1 and FlushE=0.
- Reset asserted in cycle 2 of a divide → MdBusy=0 immediately and no MdDone. A new multiply started afterwards completes normally.
- STALL_CTRL_PERF_EN defined, 10 stall cycles → StallCnt=10. With the macro undefined, StallCnt stays 0.
